demux_1tn_reg: RTL and testbench
================================

Name: demux_1tn_reg

Overview:
- Parametrised, registered successor to the fixed 32-bit 1-to-8 demux.
- Routes one valid/ready input stream to one of N = 2**SEL_W output channels, or to all channels at once in broadcast mode.
- Each channel has a one-entry output register with its own valid/ready handshake, so a stalled consumer blocks only traffic addressed to it.
- Used between pipeline stages where one producer feeds several consumers, such as issue to functional-unit queues.

Parameters:
- WIDTH, 32, data width in bits of the input and of each output channel.
- SEL_W, 3, select width; channel count N = 2**SEL_W (minimum SEL_W = 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid and in_ready are both 1.
- in_sel  input  SEL_W  destination channel index (ignored when in_bcast = 1).
- in_bcast  input  1  broadcast: deliver the word to all N channels.
- in_data  input  WIDTH  payload.
- out_valid  output  N  bit k = channel k holds a word.
- out_ready  input  N  bit k = consumer k takes the word this cycle.
- out_data  output  N*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- busy  output  1  OR of out_valid.

Behaviour:
- Per-channel state:
  - full[k] drives out_valid[k].
  - data register dreg[k] drives out_data slice k.
- Drain and free conditions:
  - drain[k] = full[k] & out_ready[k].
  - free[k] = ~full[k] | out_ready[k]. A full slot can be reloaded in the same cycle it drains.
- in_ready is combinational, with no combinational path from in_valid:
  - unicast: in_ready = free[in_sel];
  - broadcast: in_ready = AND of free over all k;
  - forced to 0 while rst = 1.
- accept = in_valid & in_ready.
- Per-channel update at each rising edge, in priority order:
  1. rst = 1: full[k] <= 0, dreg[k] <= 0.
  2. Else, accept and channel k targeted (k == in_sel, or in_bcast = 1): full[k] <= 1, dreg[k] <= in_data.
  3. Else, drain[k]: full[k] <= 0, dreg[k] holds.
  4. Otherwise hold.
- Latency:
  - A word accepted at edge t is presented on out_valid/out_data from edge t onward, i.e. visible in the cycle after acceptance.
  - Minimum input-to-consumer latency is 1 cycle.
- Throughput: one word per cycle per channel when out_ready[k] is held at 1. Back-to-back words to the same channel need no bubble.
- Untargeted channels are unaffected by an accept, apart from their own drain.
- Broadcast is all-or-nothing:
  - never partially delivered;
  - stalls until every slot is free or draining in the same cycle.
- out_data of an empty slot holds the last value (0 after reset), never X. Consumers must qualify with out_valid.
- If in_valid = 0, in_sel, in_bcast and in_data are don't-care; no state changes except drains.
- Ordering: words to one channel are delivered in acceptance order. No ordering is guaranteed across channels.
- Reset mid-operation: all buffered words are discarded, with no output handshake. out_valid = 0 and busy = 0 from the first edge with rst = 1.
- busy = |full, registered-derived (no input dependence).

Test Plan:
- Reset with all slots full.
  - Stimulus: load channels 0..7, then assert rst for 1 cycle.
  - Required: out_valid = 8'h00, busy = 0, every out_data slice = 0, in_ready = 0 while rst = 1.
- Unicast routing, WIDTH=32, SEL_W=3.
  - Stimulus: send 32'hA000_000k to in_sel = k for k = 0..7, with out_ready = 0.
  - Required:
    - each word appears only in slice k, one cycle after its accept;
    - out_valid ends at 8'hFF;
    - a further in_valid to channel 3 sees in_ready = 0.
- Per-channel backpressure.
  - Stimulus: channel 2 full with out_ready[2] = 0, channel 5 empty.
  - Required:
    - word to sel 2: in_ready = 0 and the word is held;
    - word to sel 5: accepted the same cycle, out_valid[5] = 1 next cycle;
    - raising out_ready[2] allows the sel-2 word to be accepted in that same cycle.
- Streaming.
  - Stimulus: out_ready[4] = 1 constant; 16 consecutive words 0..15 to sel 4 with in_valid = 1.
  - Required: in_ready = 1 every cycle; out_data[4] shows 0..15 on consecutive cycles; no drops or duplicates.
- Broadcast.
  - Stimulus: channel 6 full with out_ready[6] = 0; in_bcast = 1, data 32'hDEAD_BEEF.
  - Required:
    - in_ready = 0 and no slot loads;
    - once out_ready[6] = 1, accepted that cycle;
    - next cycle out_valid = 8'hFF and all slices = 32'hDEAD_BEEF.
- Parameter sweep.
  - Stimulus: repeat the unicast and streaming scenarios at WIDTH=8/SEL_W=1 and WIDTH=64/SEL_W=4.
  - Required: routing to channels 1 and 15 respectively is correct; out_data slice boundaries are correct.

Source files
------------

// File: rtl/demux_1tn_reg.sv
// Registered 1-to-N stream demultiplexer with per-channel one-entry output slots.
// Each channel has its own valid/ready handshake, and there is an all-or-nothing broadcast mode.
module demux_1tn_reg #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SEL_W-1:0]                  in_sel,
    input  logic                              in_bcast,
    input  logic [WIDTH-1:0]                  in_data,
    output logic [(1<<SEL_W)-1:0]             out_valid,
    input  logic [(1<<SEL_W)-1:0]             out_ready,
    output logic [((1<<SEL_W)*WIDTH)-1:0]     out_data,
    output logic                              busy
);

    localparam int N = 1 << SEL_W;

    logic [N-1:0]       full_q;
    logic [N-1:0]       full_d;
    logic [N*WIDTH-1:0] data_q;
    logic [N*WIDTH-1:0] data_d;
    logic               busy_q;
    logic               busy_d;
    logic [N-1:0]       free_s;
    logic [N-1:0]       drain_s;
    logic               accept_s;

    // Slot availability: empty, or emptying this cycle so it can be reloaded at once
    always_comb begin
        free_s  = ~full_q | out_ready;
        drain_s = full_q & out_ready;
    end

    // Input handshake; broadcast needs every slot, and nothing is accepted during reset
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &free_s;
        end else begin
            in_ready = free_s[in_sel];
        end
    end

    assign accept_s = in_valid & in_ready;

    // Per-channel next state: a load beats a drain, untargeted slots only drain
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        for (int k = 0; k < N; k++) begin
            if (accept_s && (in_bcast || (in_sel == SEL_W'(k)))) begin
                full_d[k]                 = 1'b1;
                data_d[k*WIDTH +: WIDTH] = in_data;
            end else if (drain_s[k]) begin
                full_d[k] = 1'b0;
            end else begin
                full_d[k] = full_q[k];
            end
        end
        busy_d = |full_d;
    end

    // Slot registers with synchronous reset discarding all buffered words
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_demux_1tn_reg.sv
// Directed self-checking bench for demux_1tn_reg at three parameter points.
// Inputs change 1 time unit after the rising edge; in_ready is sampled on the falling edge.
module tb_demux_1tn_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          iv, ib, ir, bz;
    logic [2:0]    is;
    logic [31:0]   id;
    logic [7:0]    ov, ordy;
    logic [255:0]  od;

    logic          iv_a, ib_a, ir_a, bz_a;
    logic [0:0]    is_a;
    logic [7:0]    id_a;
    logic [1:0]    ov_a, ordy_a;
    logic [15:0]   od_a;

    logic          iv_b, ib_b, ir_b, bz_b;
    logic [3:0]    is_b;
    logic [63:0]   id_b;
    logic [15:0]   ov_b, ordy_b;
    logic [1023:0] od_b;

    int tests = 0;
    int fails = 0;

    demux_1tn_reg #(.WIDTH(32), .SEL_W(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_sel(is),
        .in_bcast(ib), .in_data(id), .out_valid(ov), .out_ready(ordy),
        .out_data(od), .busy(bz)
    );

    demux_1tn_reg #(.WIDTH(8), .SEL_W(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_sel(is_a),
        .in_bcast(ib_a), .in_data(id_a), .out_valid(ov_a), .out_ready(ordy_a),
        .out_data(od_a), .busy(bz_a)
    );

    demux_1tn_reg #(.WIDTH(64), .SEL_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_sel(is_b),
        .in_bcast(ib_b), .in_data(id_b), .out_valid(ov_b), .out_ready(ordy_b),
        .out_data(od_b), .busy(bz_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b1; ib = 1'b0; is = 3'd0; id = 32'h1234_5678; ordy = 8'h00;
        iv_a = 1'b0; ib_a = 1'b0; is_a = 1'b0; id_a = 8'h00; ordy_a = 2'b00;
        iv_b = 1'b0; ib_b = 1'b0; is_b = 4'd0; id_b = 64'h0; ordy_b = 16'h0000;
        tick();
        @(negedge clk);
        tests++; if (ir !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", ir); end
        tick();
        tests++; if (ov !== 8'h00) begin fails++; $display("FAIL reset_init_valid: got %h expected 00", ov); end
        tests++; if (od !== 256'h0) begin fails++; $display("FAIL reset_init_data: got %h expected 0", od); end
        tests++; if (ov_a !== 2'b00 || od_a !== 16'h0) begin fails++; $display("FAIL reset_init_small: got %b/%h expected 00/0000", ov_a, od_a); end
        tests++; if (ov_b !== 16'h0 || od_b !== 1024'h0) begin fails++; $display("FAIL reset_init_wide: got valid %h expected 0000", ov_b); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            iv = 1'b1; is = 3'(k); id = 32'h5000_0000 | 32'(k);
            tick();
        end
        iv = 1'b0;
        tests++; if (ov !== 8'hFF || bz !== 1'b1) begin fails++; $display("FAIL reset_preload: got valid %h busy %b expected FF 1", ov, bz); end
        rst = 1'b1; iv = 1'b1; is = 3'd0;
        @(negedge clk);
        tests++; if (ir !== 1'b0) begin fails++; $display("FAIL reset_full_in_ready: got %b expected 0", ir); end
        tick();
        tests++; if (ov !== 8'h00) begin fails++; $display("FAIL reset_full_valid: got %h expected 00", ov); end
        tests++; if (bz !== 1'b0) begin fails++; $display("FAIL reset_full_busy: got %b expected 0", bz); end
        tests++; if (od !== 256'h0) begin fails++; $display("FAIL reset_full_data: got %h expected 0", od); end
        rst = 1'b0; iv = 1'b0;
    endtask

    task automatic test_unicast();
        logic [31:0] exp_d [8];
        logic [7:0]  exp_v;
        exp_v = 8'h00;
        for (int j = 0; j < 8; j++) exp_d[j] = 32'h0;
        ordy = 8'h00; ib = 1'b0;
        for (int k = 0; k < 8; k++) begin
            iv = 1'b1; is = 3'(k); id = 32'hA000_0000 | 32'(k);
            @(negedge clk);
            tests++; if (ir !== 1'b1) begin fails++; $display("FAIL unicast_ready ch%0d: got %b expected 1", k, ir); end
            tick();
            exp_v[k] = 1'b1;
            exp_d[k] = 32'hA000_0000 | 32'(k);
            tests++; if (ov !== exp_v) begin fails++; $display("FAIL unicast_valid ch%0d: got %h expected %h", k, ov, exp_v); end
            for (int j = 0; j < 8; j++) begin
                tests++;
                if (od[j*32 +: 32] !== exp_d[j]) begin
                    fails++; $display("FAIL unicast_slice ch%0d slice%0d: got %h expected %h", k, j, od[j*32 +: 32], exp_d[j]);
                end
            end
        end
        iv = 1'b1; is = 3'd3; id = 32'hFFFF_0003;
        @(negedge clk);
        tests++; if (ir !== 1'b0) begin fails++; $display("FAIL unicast_full_ready: got %b expected 0", ir); end
        tick();
        iv = 1'b0;
        tests++; if (od[3*32 +: 32] !== 32'hA000_0003) begin fails++; $display("FAIL unicast_full_hold: got %h expected A0000003", od[3*32 +: 32]); end
        ordy = 8'hFF;
        tick();
        ordy = 8'h00;
        tests++; if (ov !== 8'h00) begin fails++; $display("FAIL unicast_drain: got %h expected 00", ov); end
    endtask

    task automatic test_backpressure();
        ordy = 8'h00; ib = 1'b0;
        iv = 1'b1; is = 3'd2; id = 32'hB000_0002;
        tick();
        id = 32'hB000_0022;
        @(negedge clk);
        tests++; if (ir !== 1'b0) begin fails++; $display("FAIL bp_stall_ready: got %b expected 0", ir); end
        tick();
        tests++; if (ov !== 8'h04 || od[2*32 +: 32] !== 32'hB000_0002) begin fails++; $display("FAIL bp_stall_hold: got %h/%h expected 04/B0000002", ov, od[2*32 +: 32]); end
        is = 3'd5; id = 32'hB000_0005;
        @(negedge clk);
        tests++; if (ir !== 1'b1) begin fails++; $display("FAIL bp_other_ready: got %b expected 1", ir); end
        tick();
        tests++; if (ov !== 8'h24 || od[5*32 +: 32] !== 32'hB000_0005) begin fails++; $display("FAIL bp_other_load: got %h/%h expected 24/B0000005", ov, od[5*32 +: 32]); end
        is = 3'd2; id = 32'hB000_0022; ordy = 8'h04;
        @(negedge clk);
        tests++; if (ir !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", ir); end
        tick();
        ordy = 8'h00; iv = 1'b0;
        tests++; if (ov !== 8'h24 || od[2*32 +: 32] !== 32'hB000_0022) begin fails++; $display("FAIL bp_reload: got %h/%h expected 24/B0000022", ov, od[2*32 +: 32]); end
        ordy = 8'hFF;
        tick();
        ordy = 8'h00;
        tests++; if (ov !== 8'h00 || bz !== 1'b0) begin fails++; $display("FAIL bp_drain: got %h/%b expected 00/0", ov, bz); end
    endtask

    task automatic test_stream();
        ordy = 8'h10; ib = 1'b0;
        for (int i = 0; i < 16; i++) begin
            iv = 1'b1; is = 3'd4; id = 32'(i);
            @(negedge clk);
            tests++; if (ir !== 1'b1) begin fails++; $display("FAIL stream_ready word%0d: got %b expected 1", i, ir); end
            tick();
            tests++; if (ov !== 8'h10 || od[4*32 +: 32] !== 32'(i)) begin fails++; $display("FAIL stream_word%0d: got %h/%h expected 10/%h", i, ov, od[4*32 +: 32], 32'(i)); end
        end
        iv = 1'b0;
        tick();
        tests++; if (ov !== 8'h00) begin fails++; $display("FAIL stream_end: got %h expected 00", ov); end
        ordy = 8'h00;
    endtask

    task automatic test_broadcast();
        ordy = 8'h00;
        iv = 1'b1; ib = 1'b0; is = 3'd6; id = 32'h6666_6666;
        tick();
        ib = 1'b1; is = 3'd3; id = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++; if (ir !== 1'b0) begin fails++; $display("FAIL bcast_stall_ready: got %b expected 0", ir); end
        tick();
        tests++; if (ov !== 8'h40) begin fails++; $display("FAIL bcast_stall_valid: got %h expected 40", ov); end
        tests++; if (od[6*32 +: 32] !== 32'h6666_6666 || od[0 +: 32] !== 32'hA000_0000) begin fails++; $display("FAIL bcast_stall_data: got %h/%h expected 66666666/A0000000", od[6*32 +: 32], od[0 +: 32]); end
        ordy = 8'h40;
        @(negedge clk);
        tests++; if (ir !== 1'b1) begin fails++; $display("FAIL bcast_release_ready: got %b expected 1", ir); end
        tick();
        ordy = 8'h00; iv = 1'b0; ib = 1'b0;
        tests++; if (ov !== 8'hFF || bz !== 1'b1) begin fails++; $display("FAIL bcast_valid: got %h/%b expected FF/1", ov, bz); end
        for (int j = 0; j < 8; j++) begin
            tests++;
            if (od[j*32 +: 32] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bcast_slice%0d: got %h expected DEADBEEF", j, od[j*32 +: 32]); end
        end
        ordy = 8'hFF;
        tick();
        ordy = 8'h00;
    endtask

    task automatic test_sweep_small();
        logic [7:0] w;
        ordy_a = 2'b00; ib_a = 1'b0;
        iv_a = 1'b1; is_a = 1'b0; id_a = 8'hA0;
        @(negedge clk);
        tests++; if (ir_a !== 1'b1) begin fails++; $display("FAIL small_ready: got %b expected 1", ir_a); end
        tick();
        is_a = 1'b1; id_a = 8'hA1;
        tick();
        tests++; if (ov_a !== 2'b11 || od_a !== 16'hA1A0) begin fails++; $display("FAIL small_route: got %b/%h expected 11/A1A0", ov_a, od_a); end
        id_a = 8'h55;
        @(negedge clk);
        tests++; if (ir_a !== 1'b0) begin fails++; $display("FAIL small_full_ready: got %b expected 0", ir_a); end
        tick();
        iv_a = 1'b0;
        ordy_a = 2'b11;
        tick();
        ordy_a = 2'b10;
        for (int i = 0; i < 4; i++) begin
            w = 8'h10 + 8'(i);
            iv_a = 1'b1; is_a = 1'b1; id_a = w;
            tick();
            tests++; if (ov_a !== 2'b10 || od_a !== {w, 8'hA0}) begin fails++; $display("FAIL small_stream%0d: got %b/%h expected 10/%h", i, ov_a, od_a, {w, 8'hA0}); end
        end
        iv_a = 1'b0; ordy_a = 2'b00;
    endtask

    task automatic test_sweep_wide();
        logic [63:0] w;
        ordy_b = 16'h0000; ib_b = 1'b0;
        iv_b = 1'b1; is_b = 4'd15; id_b = 64'hFEDC_BA98_7654_3210;
        @(negedge clk);
        tests++; if (ir_b !== 1'b1) begin fails++; $display("FAIL wide_ready: got %b expected 1", ir_b); end
        tick();
        tests++; if (ov_b !== 16'h8000 || od_b[15*64 +: 64] !== 64'hFEDC_BA98_7654_3210) begin fails++; $display("FAIL wide_route15: got %h/%h expected 8000/FEDCBA9876543210", ov_b, od_b[15*64 +: 64]); end
        tests++; if (od_b[959:0] !== 960'h0) begin fails++; $display("FAIL wide_low_slices: got nonzero expected 0"); end
        is_b = 4'd0; id_b = 64'h0123_4567_89AB_CDEF;
        tick();
        tests++; if (ov_b !== 16'h8001 || od_b[0 +: 64] !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL wide_route0: got %h/%h expected 8001/0123456789ABCDEF", ov_b, od_b[0 +: 64]); end
        is_b = 4'd15;
        @(negedge clk);
        tests++; if (ir_b !== 1'b0) begin fails++; $display("FAIL wide_full_ready: got %b expected 0", ir_b); end
        tick();
        iv_b = 1'b0; ordy_b = 16'hFFFF;
        tick();
        ordy_b = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            w = {32'(i), 32'hCAFE_F00D};
            iv_b = 1'b1; is_b = 4'd15; id_b = w;
            tick();
            tests++; if (ov_b !== 16'h8000 || od_b[15*64 +: 64] !== w) begin fails++; $display("FAIL wide_stream%0d: got %h/%h expected 8000/%h", i, ov_b, od_b[15*64 +: 64], w); end
        end
        iv_b = 1'b0; ordy_b = 16'h0000;
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_backpressure();
        test_stream();
        test_broadcast();
        test_sweep_small();
        test_sweep_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
